alu_share_arbiter: RTL and testbench

//  Shares one combinational 32-bit MIPS ALU (a, b, aluc -> r, zero, carry, negative, overflow, flag)

---
 rtl/alu_share_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//   Time-shares one external combinational 32-bit MIPS ALU among NREQ
//   requesters. A round-robin grant picks one (a, b, aluc) request at a time.
//   The operands are held in registers, so the ALU sees them stable for a full
//   EXEC cycle. The result and flags are registered and returned to the owning
//   requester over a valid/ready response channel.
//   Each op walks IDLE -> EXEC -> RESP -> IDLE. An accept at cycle T gives
//   resp_valid at T+2, and an op takes at least 3 cycles.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready is a one-hot
//                     accept pulse, combinational in IDLE)
//   req_a/b/aluc      packed per-requester operands and opcode
//   resp_valid/ready  per-requester response handshake (valid is one-hot)
//   resp_r/flags/err  registered result, {zero,carry,negative,overflow,flag},
//                     unsupported-opcode error
//   resp_id           index of the requester that owns the current result
//   alu_*             connection to the shared ALU
//   busy              high while an op is in EXEC or RESP
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ*6-1:0]   req_aluc,
    output logic [NREQ-1:0]     resp_valid,
    input  logic [NREQ-1:0]     resp_ready,
    output logic [31:0]         resp_r,
    output logic [4:0]          resp_flags,
    output logic                resp_err,
    output logic [IDW-1:0]      resp_id,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [5:0]          alu_aluc,
    input  logic [31:0]         alu_r,
    input  logic                alu_zero,
    input  logic                alu_carry,
    input  logic                alu_negative,
    input  logic                alu_overflow,
    input  logic                alu_flag,
    output logic                busy
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 6;
    localparam int unsigned FW  = 5;

    localparam logic [OPW-1:0] OP_SLT  = 6'b101010;
    localparam logic [OPW-1:0] OP_SLTU = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [DW-1:0]   op_a_q, op_a_d;
    logic [DW-1:0]   op_b_q, op_b_d;
    logic [OPW-1:0]  op_aluc_q, op_aluc_d;
    logic [DW-1:0]   res_r_q, res_r_d;
    logic [FW-1:0]   res_flags_q, res_flags_d;
    logic            res_err_q, res_err_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic            busy_q, busy_d;

    logic            grant_found_c;
    logic [IDW-1:0]  grant_idx_c;
    int unsigned     cand_c;
    logic [NREQ-1:0] req_ready_c;

    // Opcodes the shared ALU implements; everything else (JR included) errors.
    function automatic logic op_supported(input logic [OPW-1:0] op);
        logic ok;
        case (op)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011,
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111,
            6'b001111: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        grant_found_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = (32'(last_grant_q) + k) % NREQ;
            if (!grant_found_c && req_valid[IDW'(cand_c)]) begin
                grant_found_c = 1'b1;
                grant_idx_c   = IDW'(cand_c);
            end
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_aluc_d    = op_aluc_q;
        res_r_d      = res_r_q;
        res_flags_d  = res_flags_q;
        res_err_d    = res_err_q;
        req_ready_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_c) begin
                    req_ready_c[grant_idx_c] = 1'b1;
                    op_a_d    = req_a[DW*32'(grant_idx_c) +: DW];
                    op_b_d    = req_b[DW*32'(grant_idx_c) +: DW];
                    op_aluc_d = req_aluc[OPW*32'(grant_idx_c) +: OPW];
                    id_d      = grant_idx_c;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_supported(op_aluc_q)) begin
                    res_r_d   = alu_r;
                    res_err_d = 1'b0;
                    // The ALU only drives flag for slt/sltu; mask it otherwise.
                    res_flags_d = {alu_zero, alu_carry, alu_negative, alu_overflow,
                                   ((op_aluc_q == OP_SLT) || (op_aluc_q == OP_SLTU))
                                   ? alu_flag : 1'b0};
                end else begin
                    res_r_d     = '0;
                    res_flags_d = '0;
                    res_err_d   = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready[id_q]) begin
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_RESP) ? (NREQ'(1) << id_d) : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_aluc_q    <= '0;
            res_r_q      <= '0;
            res_flags_q  <= '0;
            res_err_q    <= 1'b0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_aluc_q    <= op_aluc_d;
            res_r_q      <= res_r_d;
            res_flags_q  <= res_flags_d;
            res_err_q    <= res_err_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Accept pulse is suppressed while reset is asserted.
    assign req_ready  = rst_n ? req_ready_c : '0;

    assign resp_valid = resp_valid_q;
    assign resp_r     = res_r_q;
    assign resp_flags = res_flags_q;
    assign resp_err   = res_err_q;
    assign resp_id    = id_q;
    assign busy       = busy_q;

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_aluc   = op_aluc_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter. A small behavioural ALU answers the
//   DUT's alu_* port. Its flag output is 1 for every non-slt op and its
//   outputs are junk for unsupported opcodes, so masking in the DUT is
//   observable. All driving and checking happens on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] ADDU = 6'b100001;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] SUBU = 6'b100011;
    localparam logic [5:0] AND_ = 6'b100100;
    localparam logic [5:0] OR_  = 6'b100101;
    localparam logic [5:0] XOR_ = 6'b100110;
    localparam logic [5:0] NOR_ = 6'b100111;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] SLTU = 6'b101011;
    localparam logic [5:0] JR   = 6'b001000;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ*6-1:0]   req_aluc;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready;
    logic [31:0]         resp_r;
    logic [4:0]          resp_flags;
    logic                resp_err;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         alu_a;
    logic [31:0]         alu_b;
    logic [5:0]          alu_aluc;
    logic [31:0]         alu_r;
    logic                alu_zero;
    logic                alu_carry;
    logic                alu_negative;
    logic                alu_overflow;
    logic                alu_flag;
    logic                busy;

    int n_total = 0;
    int n_bad   = 0;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_aluc     (req_aluc),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_r       (resp_r),
        .resp_flags   (resp_flags),
        .resp_err     (resp_err),
        .resp_id      (resp_id),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_aluc     (alu_aluc),
        .alu_r        (alu_r),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .alu_flag     (alu_flag),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        alu_r        = 32'hDEADBEEF;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        alu_flag     = 1'b1;
        case (alu_aluc)
            ADD, ADDU: begin
                {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            SUB, SUBU: begin
                alu_r        = alu_a - alu_b;
                alu_carry    = (alu_a < alu_b);
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            AND_: begin alu_r = alu_a & alu_b;    alu_carry = 1'b0; alu_overflow = 1'b0; end
            OR_:  begin alu_r = alu_a | alu_b;    alu_carry = 1'b0; alu_overflow = 1'b0; end
            XOR_: begin alu_r = alu_a ^ alu_b;    alu_carry = 1'b0; alu_overflow = 1'b0; end
            NOR_: begin alu_r = ~(alu_a | alu_b); alu_carry = 1'b0; alu_overflow = 1'b0; end
            SLT: begin
                alu_r        = {31'b0, ($signed(alu_a) < $signed(alu_b))};
                alu_carry    = 1'b0;
                alu_overflow = 1'b0;
                alu_flag     = alu_r[0];
            end
            SLTU: begin
                alu_r        = {31'b0, (alu_a < alu_b)};
                alu_carry    = 1'b0;
                alu_overflow = 1'b0;
                alu_flag     = alu_r[0];
            end
            default: begin
            end
        endcase
        alu_zero     = (alu_r == 32'd0);
        alu_negative = alu_r[31];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op);
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_aluc[6*i +: 6] = op;
    endtask

    // One op from a single requester, starting at an IDLE falling edge.
    task automatic run_op(input string tag, input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] op,
                          input logic [31:0] exp_r, input logic [4:0] exp_f,
                          input logic exp_err);
        set_req(i, a, b, op);
        req_valid = NREQ'(1) << i;
        settle();
        chk({tag, "_ready"}, 64'(req_ready), 64'(1) << i);
        nxt();
        req_valid = '0;
        settle();
        chk({tag, "_busy"},  64'(busy), 64'd1);
        chk({tag, "_early"}, 64'(resp_valid), 64'd0);
        nxt();
        settle();
        chk({tag, "_valid"}, 64'(resp_valid), 64'(1) << i);
        chk({tag, "_id"},    64'(resp_id), 64'(i));
        chk({tag, "_r"},     64'(resp_r), 64'(exp_r));
        chk({tag, "_flags"}, 64'(resp_flags), 64'(exp_f));
        chk({tag, "_err"},   64'(resp_err), 64'(exp_err));
        resp_ready = NREQ'(1) << i;
        nxt();
        resp_ready = '0;
        settle();
        chk({tag, "_idle"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t2_r [4];
        t2_r[0] = 32'd3;
        t2_r[1] = 32'd8;
        t2_r[2] = 32'd4;
        t2_r[3] = 32'd31;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_aluc   = '0;
        resp_ready = '0;
        repeat (2) nxt();
        settle();

        // Reset state
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_aluc",  64'(alu_aluc), 64'd0);
        chk("rst_r",     64'(resp_r), 64'd0);
        chk("rst_flags", 64'(resp_flags), 64'd0);
        chk("rst_err",   64'(resp_err), 64'd0);
        chk("rst_id",    64'(resp_id), 64'd0);
        rst_n = 1'b1;

        // T1: 5 + 7
        run_op("t1", 0, 32'd5, 32'd7, ADD, 32'd12, 5'b00000, 1'b0);

        // T3: signed vs unsigned compare, and flag masking on ADD
        run_op("t3_slt",  1, 32'hFFFFFFFF, 32'd1, SLT,  32'd1, 5'b00001, 1'b0);
        run_op("t3_sltu", 1, 32'hFFFFFFFF, 32'd1, SLTU, 32'd0, 5'b10000, 1'b0);
        run_op("t3_add",  1, 32'hFFFFFFFF, 32'd1, ADD,  32'd0, 5'b11000, 1'b0);

        // T2: fresh reset, all four requesters valid, resp_ready held high
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        set_req(0, 32'd1,  32'd2, ADD);
        set_req(1, 32'd11, 32'd3, SUB);
        set_req(2, 32'd21, 32'd4, AND_);
        set_req(3, 32'd31, 32'd5, OR_);
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            settle();
            chk("t2_grant", 64'(req_ready), 64'(1) << g);
            nxt();
            settle();
            chk("t2_busy",  64'(busy), 64'd1);
            chk("t2_early", 64'(resp_valid), 64'd0);
            nxt();
            if (k == 4) req_valid = '0;
            settle();
            chk("t2_valid", 64'(resp_valid), 64'(1) << g);
            chk("t2_id",    64'(resp_id), 64'(g));
            chk("t2_r",     64'(resp_r), 64'(t2_r[g]));
            chk("t2_flags", 64'(resp_flags), 64'd0);
            nxt();
        end
        resp_ready = '0;
        settle();
        chk("t2_idle", 64'(busy), 64'd0);

        // T4: unsupported opcode from requester 2
        run_op("t4", 2, 32'h1234, 32'd1, JR, 32'd0, 5'b00000, 1'b1);

        // T5: stalled response while another requester waits
        set_req(3, 32'd100, 32'd1, ADDU);
        set_req(0, 32'hF0, 32'hFF, XOR_);
        req_valid = 4'b1001;
        settle();
        chk("t5_grant3", 64'(req_ready), 64'b1000);
        nxt();
        set_req(3, 32'hBAD, 32'hBAD, SUB);
        req_valid = 4'b0001;
        settle();
        chk("t5_exec_rdy", 64'(req_ready), 64'd0);
        nxt();
        resp_ready = 4'b0111;
        settle();
        chk("t5_valid", 64'(resp_valid), 64'b1000);
        chk("t5_r",     64'(resp_r), 64'd101);
        for (int c = 0; c < 5; c++) begin
            nxt();
            settle();
            chk("t5_hold_valid", 64'(resp_valid), 64'b1000);
            chk("t5_hold_r",     64'(resp_r), 64'd101);
            chk("t5_hold_id",    64'(resp_id), 64'd3);
            chk("t5_hold_rdy",   64'(req_ready), 64'd0);
        end
        resp_ready = 4'b1000;
        nxt();
        resp_ready = '0;
        settle();
        chk("t5_after_valid", 64'(resp_valid), 64'd0);
        chk("t5_grant0",      64'(req_ready), 64'b0001);
        nxt();
        req_valid = '0;
        settle();
        chk("t5_alu_a", 64'(alu_a), 64'hF0);
        nxt();
        settle();
        chk("t5_valid0", 64'(resp_valid), 64'b0001);
        chk("t5_r0",     64'(resp_r), 64'h0F);
        chk("t5_flags0", 64'(resp_flags), 64'd0);
        resp_ready = 4'b0001;
        nxt();
        resp_ready = '0;
        settle();
        chk("t5_idle", 64'(busy), 64'd0);

        // T6: reset in EXEC drops the op; priority restarts at requester 0
        set_req(1, 32'd1, 32'd1, ADD);
        req_valid = 4'b0010;
        settle();
        chk("t6_grant1", 64'(req_ready), 64'b0010);
        nxt();
        settle();
        chk("t6_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        set_req(0, 32'd0, 32'd0, NOR_);
        req_valid = 4'b0011;
        settle();
        chk("t6_rst_rdy", 64'(req_ready), 64'd0);
        nxt();
        settle();
        chk("t6_busy0",  64'(busy), 64'd0);
        chk("t6_valid0", 64'(resp_valid), 64'd0);
        chk("t6_alu_a",  64'(alu_a), 64'd0);
        chk("t6_aluc",   64'(alu_aluc), 64'd0);
        chk("t6_r",      64'(resp_r), 64'd0);
        rst_n = 1'b1;
        settle();
        chk("t6_grant0", 64'(req_ready), 64'b0001);
        nxt();
        req_valid = '0;
        settle();
        chk("t6_alu_nor", 64'(alu_aluc), 64'(NOR_));
        nxt();
        settle();
        chk("t6_valid", 64'(resp_valid), 64'b0001);
        chk("t6_r0",    64'(resp_r), 64'hFFFFFFFF);
        chk("t6_flags", 64'(resp_flags), 64'b00100);
        chk("t6_id",    64'(resp_id), 64'd0);
        resp_ready = 4'b1111;
        nxt();
        resp_ready = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t6_no_resp", 64'(resp_valid), 64'd0);
            nxt();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
